// File: rtl/asyn_fifo_pkg.sv
// Shared asynchronous-FIFO definitions: default geometry and binary/Gray pointer conversions.
package asyn_fifo_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 4;
    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned GRAY_MAX_W     = 32;

    // Operands are zero-extended to GRAY_MAX_W, so any pointer width up to that converts unchanged.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b = '0;
        for (int i = 0; i < int'(GRAY_MAX_W); i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: priority starts just after last_grant_i and wraps; one-hot plus encoded grant.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant_i,
    output logic [NUM_REQ-1:0]         grant_c_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx_c_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] cand_c;

    // Walk from lowest to highest priority so the highest-priority requester is written last.
    always_comb begin
        cand_c        = '0;
        grant_idx_c_o = '0;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            cand_c = IDX_W'((int'(last_grant_i) + k) % int'(NUM_REQ));
            if (req_i[cand_c]) begin
                grant_idx_c_o = cand_c;
            end
        end
        grant_c_o = (|req_i) ? (NUM_REQ'(1) << grant_idx_c_o) : '0;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Write-domain front end of the async FIFO: round-robin write-port sharing, write pointer and wfull.
// Optional FIFO_WR_ARB_LEVEL_EN adds a registered occupancy estimate on wlevel.
module fifo_wr_arbiter
    import asyn_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned NUM_REQ    = 4
) (
    input  logic                            wclk,
    input  logic                            wrst,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [ADDR_WIDTH:0]             wq2_rptr,
    output logic                            winc,
    output logic [ADDR_WIDTH-1:0]           waddr,
    output logic [DATA_WIDTH-1:0]           wdata,
    output logic [ADDR_WIDTH:0]             wptr,
    output logic                            wfull,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic [ADDR_WIDTH:0]             wlevel
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]      wbin_q, wbin_d;
    logic [PTR_W-1:0]      wgray_q, wgray_d;
    logic [PTR_W-1:0]      wptr_q;
    logic                  winc_q;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wfull_q, wfull_d;
    logic [IDX_W-1:0]      grant_id_q, grant_id_d;
    logic [IDX_W-1:0]      last_grant_q, last_grant_d;

    logic                  accept_c;
    logic [NUM_REQ-1:0]    grant_c;
    logic [IDX_W-1:0]      grant_idx_c;
    logic [PTR_W-1:0]      full_match_c;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i         (req_valid),
        .last_grant_i  (last_grant_q),
        .grant_c_o     (grant_c),
        .grant_idx_c_o (grant_idx_c)
    );

    // Full when the next write pointer equals the read pointer with its two MSBs inverted.
    always_comb begin
        accept_c     = (|req_valid) && !wfull_q;
        wbin_d       = wbin_q + PTR_W'(accept_c);
        wgray_d      = PTR_W'(bin2gray(GRAY_MAX_W'(wbin_d)));
        full_match_c = {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]};
        wfull_d      = (wgray_d == full_match_c);
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        if (accept_c) begin
            waddr_d      = wbin_q[ADDR_WIDTH-1:0];
            wdata_d      = req_data[int'(grant_idx_c)*int'(DATA_WIDTH) +: DATA_WIDTH];
            grant_id_d   = grant_idx_c;
            last_grant_d = grant_idx_c;
        end
    end

    // wptr takes the previous wgray so the slot is published on the edge its data lands in memory.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin_q       <= '0;
            wgray_q      <= '0;
            wptr_q       <= '0;
            winc_q       <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            wfull_q      <= 1'b0;
            grant_id_q   <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            wbin_q       <= wbin_d;
            wgray_q      <= wgray_d;
            wptr_q       <= wgray_q;
            winc_q       <= accept_c;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            wfull_q      <= wfull_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef FIFO_WR_ARB_LEVEL_EN
    logic [PTR_W-1:0] wlevel_q, wlevel_d;

    assign wlevel_d = wbin_d - PTR_W'(gray2bin(GRAY_MAX_W'(wq2_rptr)));

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wlevel_q <= '0;
        end else begin
            wlevel_q <= wlevel_d;
        end
    end

    assign wlevel = wlevel_q;
`else
    assign wlevel = '0;
`endif

    assign req_ready = accept_c ? grant_c : '0;
    assign winc      = winc_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign wptr      = wptr_q;
    assign wfull     = wfull_q;
    assign grant_id  = grant_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed phases plus random traffic against an occupancy/count model.
module tb_fifo_wr_arbiter;

    localparam int unsigned AW    = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned NR    = 4;
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned IW    = $clog2(NR);
    localparam int          DEPTH = 1 << AW;

    logic             wclk = 1'b0;
    logic             wrst;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic [PW-1:0]    wq2_rptr;
    logic             winc;
    logic [AW-1:0]    waddr;
    logic [DW-1:0]    wdata;
    logic [PW-1:0]    wptr;
    logic             wfull;
    logic [IW-1:0]    grant_id;
    logic [PW-1:0]    wlevel;

    int checks = 0;
    int errors = 0;

    // Model: total words written/read as plain counts, plus the expected registered outputs.
    int            wcount, rcount, last_g, m_waddr, m_gid, m_level, m_wptr_n;
    bit            m_winc, m_full;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] dat [NR];

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR)
    ) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wq2_rptr  (wq2_rptr),
        .winc      (winc),
        .waddr     (waddr),
        .wdata     (wdata),
        .wptr      (wptr),
        .wfull     (wfull),
        .grant_id  (grant_id),
        .wlevel    (wlevel)
    );

    function automatic logic [PW-1:0] gray(input int n);
        logic [PW-1:0] b;
        b = PW'(n);
        return b ^ (b >> 1);
    endfunction

    function automatic int rr_pick(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= int'(NR); k++) begin
            if (v[(last + k) % int'(NR)]) return (last + k) % int'(NR);
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < int'(NR); i++) req_data[i*int'(DW) +: DW] = dat[i];
    endtask

    task automatic model_reset();
        wcount = 0; rcount = 0; last_g = int'(NR) - 1;
        m_waddr = 0; m_gid = 0; m_level = 0; m_wptr_n = 0;
        m_winc = 1'b0; m_full = 1'b0; m_wdata = '0;
    endtask

    task automatic chk_regs();
        chk("winc", winc, m_winc);
        chk("waddr", waddr, m_waddr);
        chk("wdata", wdata, m_wdata);
        chk("grant_id", grant_id, m_gid);
        chk("wfull", wfull, m_full);
        chk("wptr", wptr, gray(m_wptr_n));
`ifdef FIFO_WR_ARB_LEVEL_EN
        chk("wlevel", wlevel, m_level);
`else
        chk("wlevel", wlevel, 0);
`endif
    endtask

    // One clock: called at a negedge with inputs set; returns at the next negedge.
    task automatic cycle(output bit acc, output int w);
        logic [NR-1:0] exp_ready;
        wq2_rptr = gray(rcount);
        drive_data();
        #1;
        acc = (req_valid != '0) && !m_full;
        w = acc ? rr_pick(req_valid, last_g) : 0;
        exp_ready = acc ? (NR'(1) << w) : '0;
        chk("req_ready", req_ready, exp_ready);
        @(posedge wclk);
        m_wptr_n = wcount;
        if (acc) begin
            m_waddr = wcount % DEPTH;
            m_wdata = dat[w];
            m_gid   = w;
            last_g  = w;
            wcount++;
        end
        m_winc  = acc;
        m_full  = (wcount - rcount) == DEPTH;
        m_level = wcount - rcount;
        @(negedge wclk);
        chk_regs();
    endtask

    task automatic do_reset();
        wrst = 1'b1;
        model_reset();
        #1;
        chk_regs();
        @(negedge wclk);
        wrst = 1'b0;
    endtask

    initial begin
        bit            acc;
        int            w, n;
        logic [PW-1:0] prevp;

        wrst = 1'b1;
        req_valid = '0;
        wq2_rptr = '0;
        for (int i = 0; i < int'(NR); i++) dat[i] = $urandom;
        drive_data();
        @(negedge wclk);
        do_reset();

        // Idle after reset
        req_valid = '0;
        for (int i = 0; i < 3; i++) cycle(acc, w);

        // Fill with all requesters valid, read side stalled
        req_valid = '1;
        for (int i = 0; i < 20; i++) begin
            cycle(acc, w);
            if (acc) dat[w] = $urandom;
            if (i < DEPTH) begin
                chk("fill_grant_seq", grant_id, i % int'(NR));
                chk("fill_waddr", waddr, i);
            end
        end
        chk("full_flag", wfull, 1);
        chk("full_wptr", wptr, 5'b11000);

        // Release one slot, refill it
        rcount = 1;
        cycle(acc, w);
        chk("release_clears_full", wfull, 0);
        cycle(acc, w);
        if (acc) dat[w] = $urandom;
        chk("refill_waddr", waddr, 0);
        chk("refill_full", wfull, 1);

        // Single requester with the read side draining
        req_valid = 4'b0100;
        n = 0;
        prevp = wptr;
        for (int cyc = 0; cyc < 400 && n < 40; cyc++) begin
            if (rcount < wcount && $urandom_range(3) != 0) rcount++;
            cycle(acc, w);
            if (acc) begin
                n++;
                dat[2] = $urandom;
            end
            chk("gray_single_step", $countones(wptr ^ prevp) <= 1, 1);
            prevp = wptr;
        end
        chk("single_req_words", n, 40);

        // Reset in the cycle after an accept
        rcount = wcount;
        req_valid = '0;
        cycle(acc, w);
        req_valid = '1;
        cycle(acc, w);
        if (acc) dat[w] = $urandom;
        chk("pre_reset_winc", winc, 1);
        do_reset();
        cycle(acc, w);
        if (acc) dat[w] = $urandom;
        chk("post_reset_grant0", grant_id, 0);
        chk("post_reset_winc", winc, 1);

        // Random traffic; slow drain first to reach full, then fast
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int i = 0; i < int'(NR); i++)
                if (!req_valid[i]) req_valid[i] = 1'($urandom_range(1));
            if (rcount < wcount && $urandom_range(3) < (cyc < 150 ? 1 : 3)) rcount++;
            cycle(acc, w);
            if (acc) begin
                req_valid[w] = 1'b0;
                dat[w] = $urandom;
            end
        end

        // Occupancy estimate
        req_valid = '0;
        do_reset();
        req_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            cycle(acc, w);
            if (acc) dat[w] = $urandom;
        end
        req_valid = '0;
        cycle(acc, w);
`ifdef FIFO_WR_ARB_LEVEL_EN
        chk("level_five", wlevel, 5);
`endif
        rcount = 2;
        cycle(acc, w);
`ifdef FIFO_WR_ARB_LEVEL_EN
        chk("level_after_read", wlevel, 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
